pkt_serializer: RTL and testbench

Downstream stage of the packetizer. Accepts one 96-bit packet per valid/ready handshake and emits it onto the NoC link as six 16-bit flits, most-significant flit first. Head and tail markers accompany the flits, and a wrapping count of sent packets is kept. The block sits between the AHB-side packetizer and the router input port, and decouples AHB write timing from link back-pressure.

---
 rtl/noc_pkg.sv | 35 +++
 rtl/pkt_serializer_if.sv | 29 ++
 rtl/pkt_serializer.sv | 99 +++++++++
 tb/tb_pkt_serializer.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Purpose: shared NoC link constants, packet field layout and serializer state encoding.
// Ports:   none (package).
package noc_pkg;

  localparam int unsigned PKT_W   = 96;
  localparam int unsigned FLIT_W  = 16;
  localparam int unsigned N_FLITS = PKT_W / FLIT_W;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned CNT_W   = 16;

  // MSB positions of the packet fields
  localparam int unsigned SRC_MSB   = 95;
  localparam int unsigned ADDR_MSB  = 79;
  localparam int unsigned NPKT_MSB  = 63;
  localparam int unsigned HSIZE_MSB = 42;
  localparam int unsigned FLAGS_MSB = 39;
  localparam int unsigned DATA_MSB  = 31;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  // Packet payload, most-significant field first
  typedef struct packed {
    logic [15:0] src;
    logic [15:0] addr;
    logic [15:0] n_pkt;
    logic [4:0]  pad;
    logic [2:0]  hsize;
    logic [7:0]  flags;
    logic [31:0] data;
  } pkt_t;

endpackage

// File: rtl/pkt_serializer_if.sv
// Purpose: packet-in / flit-out handshake bundle of the packet serializer.
// Ports:   none; signals grouped by modport.
//   slave  : serializer side (takes packets, drives flits and status)
//   master : environment side (offers packets, sinks flits)
interface pkt_serializer_if;
  import noc_pkg::*;

  pkt_t              pkt_in;
  logic              pkt_valid;
  logic              pkt_ready;
  logic [FLIT_W-1:0] flit_out;
  logic              flit_valid;
  logic              flit_ready;
  logic              flit_head;
  logic              flit_tail;
  logic              busy;
  logic [CNT_W-1:0]  pkt_cnt;

  modport slave (
    input  pkt_in, pkt_valid, flit_ready,
    output pkt_ready, flit_out, flit_valid, flit_head, flit_tail, busy, pkt_cnt
  );

  modport master (
    output pkt_in, pkt_valid, flit_ready,
    input  pkt_ready, flit_out, flit_valid, flit_head, flit_tail, busy, pkt_cnt
  );

endinterface

// File: rtl/pkt_serializer.sv
// Purpose: accepts a PKT_W packet per handshake and emits it as N_FLITS flits,
//          most-significant flit first, with head/tail markers and a wrapping
//          count of completed packets.
// Ports:
//   hclk    : clock, rising edge
//   hresetn : asynchronous active-low reset
//   bus     : pkt_serializer_if.slave (pkt_in/pkt_valid/pkt_ready,
//             flit_out/flit_valid/flit_ready/flit_head/flit_tail, busy, pkt_cnt)
module pkt_serializer
  import noc_pkg::*;
(
  input  logic            hclk,
  input  logic            hresetn,
  pkt_serializer_if.slave bus
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_FLITS - 1);

  state_e             state_q, state_d;
  logic [PKT_W-1:0]   shreg_q, shreg_d;
  logic [IDX_W-1:0]   idx_q,   idx_d;
  logic [CNT_W-1:0]   pkt_cnt_q, pkt_cnt_d;
  logic               head_q,  head_d;
  logic               tail_q,  tail_d;

  // State and datapath registers
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      idx_q     <= '0;
      pkt_cnt_q <= '0;
      head_q    <= 1'b0;
      tail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      idx_q     <= idx_d;
      pkt_cnt_q <= pkt_cnt_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
    end
  end

  // Next-state: load, shift per flit handshake, reload on tail when a packet waits
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    idx_d     = idx_q;
    pkt_cnt_d = pkt_cnt_q;
    head_d    = head_q;
    tail_d    = tail_q;
    case (state_q)
      IDLE: begin
        if (bus.pkt_valid) begin
          state_d = SEND;
          shreg_d = bus.pkt_in;
          idx_d   = '0;
          head_d  = 1'b1;
          tail_d  = 1'b0;
        end
      end
      SEND: begin
        if (bus.flit_ready) begin
          if (tail_q) begin
            pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
            if (bus.pkt_valid) begin
              shreg_d = bus.pkt_in;
              idx_d   = '0;
              head_d  = 1'b1;
              tail_d  = 1'b0;
            end else begin
              state_d = IDLE;
              idx_d   = '0;
              head_d  = 1'b0;
              tail_d  = 1'b0;
            end
          end else begin
            shreg_d = shreg_q << FLIT_W;
            idx_d   = idx_q + IDX_W'(1);
            head_d  = 1'b0;
            tail_d  = ((idx_q + IDX_W'(1)) == LAST_IDX);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Ready also opens on the tail edge so back-to-back packets have no bubble
  assign bus.pkt_ready  = (state_q == IDLE) | ((state_q == SEND) & tail_q & bus.flit_ready);
  assign bus.flit_valid = (state_q == SEND);
  assign bus.busy       = (state_q == SEND);
  assign bus.flit_out   = shreg_q[PKT_W-1 -: FLIT_W];
  assign bus.flit_head  = head_q;
  assign bus.flit_tail  = tail_q;
  assign bus.pkt_cnt    = pkt_cnt_q;

endmodule

// File: tb/tb_pkt_serializer.sv
// Purpose: self-checking bench for pkt_serializer; a queue-based reference
//          model predicts flits, markers, ready and the packet count.
module tb_pkt_serializer;

  logic clk;
  logic rst_n;

  pkt_serializer_if bus ();

  pkt_serializer dut (
    .hclk    (clk),
    .hresetn (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks;
  int          fails;
  logic [15:0] mflits [$];
  int          midx;
  logic [15:0] mcnt;
  bit          last_acc;
  bit          last_fire;
  int          n_acc;
  int          n_fire;

  function automatic logic [95:0] rnd_pkt();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [15:0] flit(input logic [95:0] p, input int i);
    return 16'(p >> (16 * (5 - i)));
  endfunction

  // {valid, head, tail, pkt_ready, busy, flit (when valid), pkt_cnt}
  function automatic logic [36:0] dut_obs();
    return {bus.flit_valid, bus.flit_head, bus.flit_tail, bus.pkt_ready, bus.busy,
            (bus.flit_valid ? bus.flit_out : 16'h0000), bus.pkt_cnt};
  endfunction

  function automatic logic [36:0] exp_obs();
    bit          v;
    logic [15:0] f;
    v = (mflits.size() != 0);
    f = v ? mflits[0] : 16'h0000;
    return {v, (v && midx == 0), (mflits.size() == 1),
            ((mflits.size() == 0) || (mflits.size() == 1 && bus.flit_ready)), v, f, mcnt};
  endfunction

  // Advance the model across the coming rising edge using the current inputs
  task automatic model_edge();
    bit          fire;
    bit          acc;
    logic [95:0] p;
    fire = (mflits.size() != 0) && bus.flit_ready;
    acc  = bus.pkt_valid && ((mflits.size() == 0) || (mflits.size() == 1 && bus.flit_ready));
    p    = bus.pkt_in;
    if (fire) begin
      void'(mflits.pop_front());
      midx++;
      if (mflits.size() == 0) mcnt++;
      n_fire++;
    end
    if (acc) begin
      midx = 0;
      for (int i = 0; i < 6; i++) mflits.push_back(flit(p, i));
      n_acc++;
    end
    last_acc  = acc;
    last_fire = fire;
  endtask

  task automatic model_clear();
    mflits.delete();
    midx = 0; mcnt = 16'h0000; last_acc = 1'b0; last_fire = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; bus.pkt_valid = 1'b0; bus.flit_ready = 1'b0; bus.pkt_in = '0;
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.flit_valid, bus.flit_head, bus.flit_tail, bus.busy, bus.flit_out, bus.pkt_cnt} !== 36'h0) begin
      fails++;
      $display("FAIL reset_values got=%h exp=0",
               {bus.flit_valid, bus.flit_head, bus.flit_tail, bus.busy, bus.flit_out, bus.pkt_cnt});
    end
    model_clear();
    @(negedge clk); rst_n = 1'b1;
    #1;
    checks++;
    if (bus.pkt_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got=%b exp=1", bus.pkt_ready); end
  endtask

  task automatic test_single();
    logic [15:0] want [6];
    logic [15:0] got [$];
    want = '{16'h0001, 16'h1234, 16'h0005, 16'h02A5, 16'hDEAD, 16'hBEEF};
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 0) begin
        bus.flit_ready = 1'b1; bus.pkt_valid = 1'b1; last_acc = 1'b0;
        bus.pkt_in = 96'h0001_1234_0005_02A5_DEAD_BEEF;
      end else if (last_acc) begin
        bus.pkt_valid = 1'b0; bus.pkt_in = rnd_pkt();
      end
      #1;
      checks++;
      if (dut_obs() !== exp_obs()) begin fails++; $display("FAIL single cyc%0d got=%h exp=%h", c, dut_obs(), exp_obs()); end
      if (bus.flit_valid && bus.flit_ready) got.push_back(bus.flit_out);
      model_edge();
    end
    checks++;
    if (got.size() != 6) begin
      fails++; $display("FAIL single_nflits got=%0d exp=6", got.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (got[i] !== want[i]) begin fails++; $display("FAIL single_flit%0d got=%h exp=%h", i, got[i], want[i]); end
      end
    end
    checks++;
    if (bus.pkt_cnt !== 16'd1 || bus.busy !== 1'b0) begin
      fails++; $display("FAIL single_end cnt=%h busy=%b exp cnt=0001 busy=0", bus.pkt_cnt, bus.busy);
    end
  endtask

  task automatic test_backpressure();
    logic [95:0] p;
    logic [15:0] got [$];
    int          stall;
    p = rnd_pkt(); stall = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (c == 0) begin
        bus.pkt_in = p; bus.pkt_valid = 1'b1; last_acc = 1'b0;
      end else if (last_acc) begin
        bus.pkt_valid = 1'b0; bus.pkt_in = rnd_pkt();
      end
      bus.flit_ready = 1'b1;
      if (mflits.size() != 0 && midx == 2 && stall < 3) begin bus.flit_ready = 1'b0; stall++; end
      #1;
      checks++;
      if (dut_obs() !== exp_obs()) begin fails++; $display("FAIL backpressure cyc%0d got=%h exp=%h", c, dut_obs(), exp_obs()); end
      if (!bus.flit_ready && stall > 0) begin
        checks++;
        if (bus.flit_valid !== 1'b1 || bus.flit_out !== flit(p, 2)) begin
          fails++; $display("FAIL bp_hold v=%b got=%h exp=%h", bus.flit_valid, bus.flit_out, flit(p, 2));
        end
      end
      if (bus.flit_valid && bus.flit_ready) got.push_back(bus.flit_out);
      model_edge();
    end
    checks++;
    if (got.size() != 6) begin
      fails++; $display("FAIL bp_nflits got=%0d exp=6", got.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (got[i] !== flit(p, i)) begin fails++; $display("FAIL bp_flit%0d got=%h exp=%h", i, got[i], flit(p, i)); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [95:0] p0, p1;
    logic [15:0] cnt0;
    int          first_c, last_c, nf;
    p0 = rnd_pkt(); p1 = rnd_pkt(); cnt0 = mcnt; first_c = -1; last_c = -1; nf = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (c == 0) begin
        bus.pkt_in = p0; bus.pkt_valid = 1'b1; bus.flit_ready = 1'b1; last_acc = 1'b0; n_acc = 0;
      end else if (last_acc) begin
        if (n_acc == 1) bus.pkt_in = p1;
        else begin bus.pkt_valid = 1'b0; bus.pkt_in = rnd_pkt(); end
      end
      #1;
      checks++;
      if (dut_obs() !== exp_obs()) begin fails++; $display("FAIL b2b cyc%0d got=%h exp=%h", c, dut_obs(), exp_obs()); end
      if (bus.flit_valid && bus.flit_ready) begin
        if (first_c < 0) first_c = c;
        last_c = c; nf++;
      end
      model_edge();
    end
    checks++;
    if (nf != 12 || (last_c - first_c) != 11) begin
      fails++; $display("FAIL b2b_rate flits=%0d span=%0d exp flits=12 span=11", nf, last_c - first_c);
    end
    checks++;
    if (bus.pkt_cnt !== 16'(cnt0 + 16'd2)) begin fails++; $display("FAIL b2b_cnt got=%h exp=%h", bus.pkt_cnt, 16'(cnt0 + 16'd2)); end
  endtask

  task automatic test_tail_stall();
    logic [95:0] p0, p1;
    int          stall;
    p0 = rnd_pkt(); p1 = rnd_pkt(); stall = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c == 0) begin n_acc = 0; last_acc = 1'b0; end
      bus.pkt_valid  = (n_acc == 0) || (n_acc == 1 && mflits.size() == 1);
      bus.pkt_in     = (n_acc == 0) ? p0 : p1;
      bus.flit_ready = 1'b1;
      if (n_acc == 1 && mflits.size() == 1 && stall < 3) begin bus.flit_ready = 1'b0; stall++; end
      #1;
      checks++;
      if (dut_obs() !== exp_obs()) begin fails++; $display("FAIL tail_stall cyc%0d got=%h exp=%h", c, dut_obs(), exp_obs()); end
      if (!bus.flit_ready) begin
        checks++;
        if (bus.pkt_ready !== 1'b0) begin fails++; $display("FAIL tail_stall_ready got=%b exp=0", bus.pkt_ready); end
      end
      model_edge();
    end
    checks++;
    if (n_acc != 2 || stall != 3) begin fails++; $display("FAIL tail_stall_accepts got=%0d exp=2", n_acc); end
  endtask

  task automatic test_reset_mid();
    logic [95:0] p;
    p = rnd_pkt(); n_fire = 0;
    for (int c = 0; c < 12 && n_fire < 4; c++) begin
      @(negedge clk);
      if (c == 0) begin
        bus.pkt_in = p; bus.pkt_valid = 1'b1; bus.flit_ready = 1'b1; last_acc = 1'b0;
      end else if (last_acc) begin
        bus.pkt_valid = 1'b0; bus.pkt_in = rnd_pkt();
      end
      #1;
      checks++;
      if (dut_obs() !== exp_obs()) begin fails++; $display("FAIL rst_mid_pre cyc%0d got=%h exp=%h", c, dut_obs(), exp_obs()); end
      model_edge();
    end
    checks++;
    if (n_fire != 4) begin fails++; $display("FAIL rst_mid_timeout flits=%0d exp=4", n_fire); end
    @(negedge clk);
    #2 rst_n = 1'b0; bus.pkt_valid = 1'b0;
    #1;
    checks++;
    if (bus.flit_valid !== 1'b0 || bus.pkt_cnt !== 16'h0000 || bus.busy !== 1'b0) begin
      fails++; $display("FAIL rst_mid_clear v=%b cnt=%h busy=%b exp 0/0000/0", bus.flit_valid, bus.pkt_cnt, bus.busy);
    end
    model_clear();
    @(negedge clk); rst_n = 1'b1;
    p = rnd_pkt();
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      if (c == 0) begin
        bus.pkt_in = p; bus.pkt_valid = 1'b1; bus.flit_ready = 1'b1;
      end else if (last_acc) begin
        bus.pkt_valid = 1'b0; bus.pkt_in = rnd_pkt();
      end
      #1;
      checks++;
      if (dut_obs() !== exp_obs()) begin fails++; $display("FAIL rst_mid_post cyc%0d got=%h exp=%h", c, dut_obs(), exp_obs()); end
      if (c == 1) begin
        checks++;
        if (bus.flit_head !== 1'b1 || bus.flit_out !== flit(p, 0)) begin
          fails++; $display("FAIL rst_mid_head head=%b got=%h exp=%h", bus.flit_head, bus.flit_out, flit(p, 0));
        end
      end
      model_edge();
    end
  endtask

  task automatic test_wrap();
    bit saw_max;
    saw_max = 1'b0;
    @(negedge clk);
    force dut.pkt_cnt_q = 16'hFFFE;
    #1 release dut.pkt_cnt_q;
    mcnt = 16'hFFFE;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (c == 0) begin
        bus.pkt_in = rnd_pkt(); bus.pkt_valid = 1'b1; bus.flit_ready = 1'b1; last_acc = 1'b0; n_acc = 0;
      end else if (last_acc) begin
        if (n_acc == 1) bus.pkt_in = rnd_pkt();
        else begin bus.pkt_valid = 1'b0; bus.pkt_in = rnd_pkt(); end
      end
      #1;
      checks++;
      if (dut_obs() !== exp_obs()) begin fails++; $display("FAIL wrap cyc%0d got=%h exp=%h", c, dut_obs(), exp_obs()); end
      if (bus.pkt_cnt === 16'hFFFF) saw_max = 1'b1;
      model_edge();
    end
    checks++;
    if (!saw_max || bus.pkt_cnt !== 16'h0000) begin
      fails++; $display("FAIL wrap_end saw_ffff=%b cnt=%h exp 1/0000", saw_max, bus.pkt_cnt);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (c == 0) last_acc = 1'b0;
      if (!bus.pkt_valid || last_acc) begin
        bus.pkt_valid = ($urandom_range(0, 3) != 0);
        bus.pkt_in    = rnd_pkt();
      end
      bus.flit_ready = ($urandom_range(0, 3) != 0);
      #1;
      checks++;
      if (dut_obs() !== exp_obs()) begin fails++; $display("FAIL random cyc%0d got=%h exp=%h", c, dut_obs(), exp_obs()); end
      model_edge();
    end
  endtask

  initial begin
    checks = 0; fails = 0; n_acc = 0; n_fire = 0;
    model_clear();
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_tail_stall();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
